// File: rtl/sdp_fifo_ctrl.sv
// Ready/valid FIFO controller for a simple dual-port RAM with registered read address,
// with a 2-entry skid buffer hiding read latency. Optional `flush` port via SDP_FIFO_FLUSH_EN.
module sdp_fifo_ctrl #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef SDP_FIFO_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_BITS-1:0] ram_wr_addr,
    output logic [DATA_BITS-1:0] ram_wr_data,
    output logic                 ram_wr_en,
    output logic [ADDR_BITS-1:0] ram_rd_addr,
    input  logic [DATA_BITS-1:0] ram_rd_data,
    output logic [ADDR_BITS+1:0] level
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);

    logic                 run;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   ram_cnt;
    logic                 vld_p1;
    logic [1:0]           skid_cnt;
    logic [DATA_BITS-1:0] skid_head;
    logic [DATA_BITS-1:0] skid_tail;

    logic                 flush_now;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic [1:0]           occ_after_pop;
    logic [1:0]           skid_cnt_nxt;
    logic [DATA_BITS-1:0] skid_head_nxt;
    logic [DATA_BITS-1:0] skid_tail_nxt;

`ifdef SDP_FIFO_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // run holds in_ready low until the first clock after reset release
    assign in_ready = run & (ram_cnt != DEPTH_CNT) & ~flush_now;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // Only issue when the returning word is guaranteed a free skid slot
    assign occ_after_pop = skid_cnt - {1'b0, pop} + {1'b0, vld_p1};
    assign issue         = ~flush_now & (ram_cnt != '0) & (occ_after_pop < 2'd2);

    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = in_data;
    assign ram_rd_addr = rd_ptr;

    assign out_valid = (skid_cnt != 2'd0);
    assign out_data  = skid_head;
    assign level     = (ADDR_BITS + 2)'(ram_cnt) + (ADDR_BITS + 2)'(vld_p1)
                     + (ADDR_BITS + 2)'(skid_cnt);

    always_comb begin
        skid_cnt_nxt  = skid_cnt;
        skid_head_nxt = skid_head;
        skid_tail_nxt = skid_tail;
        if (pop) begin
            skid_head_nxt = skid_tail;
            skid_cnt_nxt  = skid_cnt - 2'd1;
        end
        if (vld_p1) begin
            if (skid_cnt_nxt == 2'd0) begin
                skid_head_nxt = ram_rd_data;
            end else begin
                skid_tail_nxt = ram_rd_data;
            end
            skid_cnt_nxt = skid_cnt_nxt + 2'd1;
        end
    end

    // stage 0 -> 1: pointers, RAM count and read-in-flight flag; stage 2: skid capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            vld_p1    <= 1'b0;
            skid_cnt  <= 2'd0;
            skid_head <= '0;
        end else if (flush_now) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            vld_p1    <= 1'b0;
            skid_cnt  <= 2'd0;
        end else begin
            run <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_cnt   <= ram_cnt + (ADDR_BITS + 1)'(push) - (ADDR_BITS + 1)'(issue);
            vld_p1    <= issue;
            skid_cnt  <= skid_cnt_nxt;
            skid_head <= skid_head_nxt;
        end
    end

    // Tail word is only observed once skid_cnt says it is occupied
    always_ff @(posedge clk) begin
        skid_tail <= skid_tail_nxt;
    end

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Self-checking bench for sdp_fifo_ctrl: vector table, corner-case sequences and a
// queue-based scoreboard driven by random traffic. Flush test when SDP_FIFO_FLUSH_EN is defined.
module tb_sdp_fifo_ctrl;

    localparam int AB = 6;
    localparam int DB = 14;
    localparam int DEPTH = 64;
    localparam int CAP = DEPTH + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [DB-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DB-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AB-1:0] ram_wr_addr;
    logic [DB-1:0] ram_wr_data;
    logic          ram_wr_en;
    logic [AB-1:0] ram_rd_addr;
    logic [DB-1:0] ram_rd_data;
    logic [AB+1:0] level;

    sdp_fifo_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SDP_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .ram_wr_en(ram_wr_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .level(level)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM: port B write, port A registered address
    logic [DB-1:0] mem [DEPTH];
    logic [AB-1:0] rd_addr_q = '0;
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        rd_addr_q <= ram_rd_addr;
    end
    assign ram_rd_data = mem[rd_addr_q];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [DB-1:0] q[$];
    int  wr_total = 0;
    int  n_out = 0;
    int  first_out_cyc = -1;
    int  last_out_cyc = -1;
    logic [DB-1:0] first_out_val = '0;
    logic last_push = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the FIFO content is a plain queue of accepted words
    task automatic sb_check();
        logic p;
        chk("level", 32'(level), 32'(q.size()));
        chk("capacity", 32'(q.size() <= CAP), 32'd1);
        if (out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL underflow: out_valid=1 with model empty (cycle %0d)", cyc);
            end else begin
                chk("out_data", 32'(out_data), 32'(q[0]));
                if (out_ready) begin
                    if (first_out_cyc < 0) begin
                        first_out_cyc = cyc;
                        first_out_val = out_data;
                    end
                    last_out_cyc = cyc;
                    n_out++;
                    void'(q.pop_front());
                end
            end
        end
        p = in_valid && in_ready;
        chk("wr_en", 32'(ram_wr_en), 32'(p));
        if (p) begin
            chk("wr_addr", 32'(ram_wr_addr), 32'(wr_total % DEPTH));
            chk("wr_data", 32'(ram_wr_data), 32'(in_data));
            q.push_back(in_data);
            wr_total++;
        end
        last_push = p;
        if (flush) begin
            q.delete();
            wr_total = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_check();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_marks();
        n_out = 0;
        first_out_cyc = -1;
        last_out_cyc = -1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (q.size() == 0 && !out_valid) break;
            tick();
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
    endtask

    typedef struct packed {
        logic          iv;
        logic [DB-1:0] id;
        logic          ordy;
        logic          e_irdy;
        logic          e_wen;
        logic          e_ov;
        logic          chk_d;
        logic [DB-1:0] e_od;
        logic [7:0]    e_lvl;
    } vec_t;

    vec_t vecs [11];
    int   accepted;

    initial begin
        vecs[0]  = '{1'b1, 14'h1A5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 14'h000, 8'd0};
        vecs[1]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 14'h000, 8'd1};
        vecs[2]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 14'h000, 8'd1};
        vecs[3]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 14'h1A5, 8'd1};
        vecs[4]  = '{1'b1, 14'h002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h000, 8'd0};
        vecs[5]  = '{1'b1, 14'h003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h000, 8'd1};
        vecs[6]  = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h000, 8'd2};
        vecs[7]  = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 14'h002, 8'd2};
        vecs[8]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 14'h002, 8'd2};
        vecs[9]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 14'h003, 8'd1};
        vecs[10] = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 14'h000, 8'd0};

        // Reset with a push pending
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 14'h055;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Vector table: latency and two-deep skid ordering
        for (int i = 0; i < 11; i++) begin
            in_valid = vecs[i].iv;
            in_data = vecs[i].id;
            out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_irdy));
            chk($sformatf("v%0d_wr_en", i), 32'(ram_wr_en), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
            if (vecs[i].chk_d) chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            sb_check();
            @(posedge clk);
            #1;
        end

        // Streaming 0..199 with out_ready held high
        reset_marks();
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_data = 14'(i);
            tick();
            if (!last_push) begin
                chk("stream_push_accepted", 32'd0, 32'd1);
                break;
            end
        end
        drain();
        chk("stream_count", 32'(n_out), 32'd200);
        chk("stream_no_gap", 32'(last_out_cyc - first_out_cyc), 32'd199);

        // Fill with downstream stalled
        out_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 200; k++) begin
            in_valid = 1'b1;
            in_data = 14'(k + 500);
            tick();
            if (!last_push) break;
            accepted++;
        end
        chk("full_accepted", 32'(accepted), 32'(CAP));
        in_valid = 1'b0;
        repeat (3) tick();
        chk("full_level", 32'(level), 32'(CAP));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        reset_marks();
        drain();
        chk("full_drain_count", 32'(n_out), 32'(CAP));
        chk("full_first_out", 32'(first_out_val), 32'd500);

        // Random traffic against the queue model
        for (int c = 0; c < 5000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data = 14'($urandom);
            tick();
        end
        drain();

`ifdef SDP_FIFO_FLUSH_EN
        // Flush with a RAM read in flight
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data = 14'(k + 100);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 14'h155;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_wr_en", 32'(ram_wr_en), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_level", 32'(level), 32'd0);
        repeat (2) tick();
        chk("flush_stays_empty", 32'(level), 32'd0);
        reset_marks();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 14'h3FF;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (n_out > 0) break;
            tick();
        end
        chk("flush_next_out_seen", 32'(n_out), 32'd1);
        chk("flush_next_out_val", 32'(first_out_val), 32'h3FF);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
